// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit saturating direction counters.
// Optional counters for updates/mispredicts when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor #(
  parameter int         INDEX_BITS     = 4,
  parameter logic [1:0] CTR_INIT_ALLOC = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_pc,
  output logic [15:0] predict_addr,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic [15:0] update_pc,
  input  logic        update_taken,
`ifdef BRANCH_PREDICTOR_STATS_EN
  input  logic [15:0] update_target,
  output logic [15:0] stat_updates,
  output logic [15:0] stat_mispredicts
`else
  input  logic [15:0] update_target
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 15 - INDEX_BITS;

  logic             valid_mem  [ENTRIES];
  logic [TAG_W-1:0] tag_mem    [ENTRIES];
  logic [15:0]      target_mem [ENTRIES];
  logic [1:0]       ctr_mem    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0]      fetch_tag, upd_tag;
  logic                  fetch_hit, upd_hit;
  logic [1:0]            upd_ctr;
  logic                  unused_bits;

  // Bit 0 of a word-aligned PC carries no information.
  assign unused_bits = update_pc[0];

  assign fetch_idx = fetch_pc[INDEX_BITS:1];
  assign fetch_tag = fetch_pc[15:INDEX_BITS+1];
  assign upd_idx   = update_pc[INDEX_BITS:1];
  assign upd_tag   = update_pc[15:INDEX_BITS+1];

  assign fetch_hit     = valid_mem[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign predict_taken = fetch_hit && ctr_mem[fetch_idx][1];
  assign predict_addr  = predict_taken ? target_mem[fetch_idx] : fetch_pc + 16'd2;

  assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_ctr = ctr_mem[upd_idx];

  // Lookup reads the array combinationally, so a same-cycle update is seen next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= 2'b01;
      end
    end else if (update_valid) begin
      if (upd_hit) begin
        if (update_taken) begin
          if (upd_ctr != 2'b11) ctr_mem[upd_idx] <= upd_ctr + 2'd1;
          target_mem[upd_idx] <= update_target;
        end else if (upd_ctr != 2'b00) begin
          ctr_mem[upd_idx] <= upd_ctr - 2'd1;
        end
      end else if (update_taken) begin
        valid_mem[upd_idx]  <= 1'b1;
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= update_target;
        ctr_mem[upd_idx]    <= CTR_INIT_ALLOC;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic upd_pred_taken, mispredict;

  assign upd_pred_taken = upd_hit && upd_ctr[1];
  assign mispredict = (upd_pred_taken != update_taken) ||
                      (upd_pred_taken && update_taken && (target_mem[upd_idx] != update_target));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (update_valid) begin
      stat_updates <= stat_updates + 16'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected {taken, addr} queued per driven cycle.
// Stats checks are compiled in when BRANCH_PREDICTOR_STATS_EN is defined.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic [15:0] predict_addr;
  logic        predict_taken;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  branch_predictor dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_pc     (fetch_pc),
    .predict_addr (predict_addr),
    .predict_taken(predict_taken),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
`ifdef BRANCH_PREDICTOR_STATS_EN
    .update_target(update_target),
    .stat_updates (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`else
    .update_target(update_target)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_empty_q"}, {predict_taken, predict_addr}, 17'h1FFFF);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, {predict_taken, predict_addr}, e);
    end
  endtask

  // One cycle: drive inputs after negedge, check lookup before the updating posedge.
  task automatic step(input string tag, input logic [15:0] fpc, input logic uv,
                      input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                      input logic et, input logic [15:0] ea);
    @(negedge clk);
    fetch_pc      = fpc;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    exp_q.push_back({et, ea});
    #2;
    pop_check(tag);
  endtask

  task automatic lookup(input string tag, input logic [15:0] fpc, input logic et, input logic [15:0] ea);
    step(tag, fpc, 1'b0, 16'h0000, 1'b0, 16'h0000, et, ea);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    update_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    fetch_pc = 16'h3000;
    update_valid = 1'b0;
    update_pc = 16'h0000;
    update_taken = 1'b0;
    update_target = 16'h0000;
    #1;
    exp_q.push_back({1'b0, 16'h3002});
    pop_check("in_reset");
    do_reset();

    lookup("rst_3000", 16'h3000, 1'b0, 16'h3002);
    lookup("wrap_fffe", 16'hFFFE, 1'b0, 16'h0000);
    step("alloc_3004", 16'h3000, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'h3002);
    lookup("hit_ctr2", 16'h3004, 1'b1, 16'h3100);
    step("nt1", 16'h3004, 1'b1, 16'h3004, 1'b0, 16'h0000, 1'b1, 16'h3100);
    step("nt2", 16'h3004, 1'b1, 16'h3004, 1'b0, 16'h0000, 1'b0, 16'h3006);
    step("nt3_sat0", 16'h3004, 1'b1, 16'h3004, 1'b0, 16'h0000, 1'b0, 16'h3006);
    step("t1_from0", 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'h3006);
    step("t2_from1", 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'h3006);
    lookup("ctr2_again", 16'h3004, 1'b1, 16'h3100);
    step("t_to3", 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b1, 16'h3100);
    step("t_sat3", 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b1, 16'h3100);
    step("nt_3to2", 16'h3004, 1'b1, 16'h3004, 1'b0, 16'h0000, 1'b1, 16'h3100);
    lookup("after_sat", 16'h3004, 1'b1, 16'h3100);
    step("tgt_chg", 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3120, 1'b1, 16'h3100);
    lookup("new_tgt", 16'h3004, 1'b1, 16'h3120);
    step("alias_alloc", 16'h3004, 1'b1, 16'h4004, 1'b1, 16'h4200, 1'b1, 16'h3120);
    lookup("alias_old", 16'h3004, 1'b0, 16'h3006);
    lookup("alias_new", 16'h4004, 1'b1, 16'h4200);
    step("miss_nt", 16'h4004, 1'b1, 16'h5004, 1'b0, 16'h5500, 1'b1, 16'h4200);
    lookup("miss_nt_keep", 16'h4004, 1'b1, 16'h4200);
    lookup("miss_nt_noalloc", 16'h5004, 1'b0, 16'h5006);
    step("same_cycle", 16'h3008, 1'b1, 16'h3008, 1'b1, 16'h3300, 1'b0, 16'h300A);
    lookup("same_next", 16'h3008, 1'b1, 16'h3300);

    @(negedge clk);
    reset = 1'b1;
    update_valid = 1'b0;
    fetch_pc = 16'h3008;
    exp_q.push_back({1'b0, 16'h300A});
    #2;
    pop_check("midreset_3008");
    fetch_pc = 16'h4004;
    exp_q.push_back({1'b0, 16'h4006});
    #1;
    pop_check("midreset_4004");
    @(negedge clk);
    reset = 1'b0;
    lookup("post_reset", 16'h3008, 1'b0, 16'h300A);

`ifdef BRANCH_PREDICTOR_STATS_EN
    do_reset();
    check_val("stat_upd_rst", {1'b0, stat_updates}, 17'h0);
    check_val("stat_mis_rst", {1'b0, stat_mispredicts}, 17'h0);
    step("s1_miss_t", 16'h0000, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'h0002);
    step("s2_hit_ok", 16'h0000, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'h0002);
    step("s3_tgt", 16'h0000, 1'b1, 16'h3004, 1'b1, 16'h3180, 1'b0, 16'h0002);
    step("s4_dir", 16'h0000, 1'b1, 16'h3004, 1'b0, 16'h0000, 1'b0, 16'h0002);
    step("s5_miss_nt", 16'h0000, 1'b1, 16'h5004, 1'b0, 16'h0000, 1'b0, 16'h0002);
    @(negedge clk);
    update_valid = 1'b0;
    #2;
    check_val("stat_upd", {1'b0, stat_updates}, {1'b0, 16'd5});
    check_val("stat_mis", {1'b0, stat_mispredicts}, {1'b0, 16'd3});
    do_reset();
    check_val("stat_upd_clr", {1'b0, stat_updates}, 17'h0);
    check_val("stat_mis_clr", {1'b0, stat_mispredicts}, 17'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
